uart_tx_engine: RTL

Transmit stage of the software-defined UART. Sits directly downstream of the UART register file and consumes its outputs: the transmit data byte, the control bits (TX enable, parity, stop bits) and the baud divisor. It serialises each byte onto `txd` as an 8-bit asynchronous frame. It returns the data-register-empty and transmit-complete status bits for the register file's status register. It holds one byte of buffering plus a shift register, so software can queue the next byte while the current one shifts out.

---
 rtl/uart_tx_engine.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one-byte holding buffer feeding a shift register that
// serialises start, 8 data bits (LSB first), optional parity and 1-2 stop bits.
module uart_tx_engine #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock_50MHz,
  input  logic                 reset,
  input  logic                 txEnable,
  input  logic                 parityEnable,
  input  logic                 parityOdd,
  input  logic                 twoStopBits,
  input  logic [DIV_WIDTH-1:0] baudDivisor,
  input  logic [7:0]           dataIn,
  input  logic                 dataWrite,
  input  logic                 txcClear,
  output logic                 txd,
  output logic                 udre,
  output logic                 txc,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_next;
  logic [7:0]           buf_q;
  logic [7:0]           shift_q, shift_next;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] timer_q, timer_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 par_en_q, par_bit_q, two_stop_q;
  logic                 txd_next, busy_next;
  logic                 load, set_txc, bit_end, can_load;

  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign bit_end  = (timer_q == div_q);
  // udre doubles as the buffer-empty flag, so a full buffer is simply ~udre
  assign can_load = txEnable && !udre;

  always_comb begin
    state_next    = state;
    shift_next    = shift_q;
    timer_next    = timer_q;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    load          = 1'b0;
    set_txc       = 1'b0;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (can_load) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_next   = '0;
          bit_cnt_next = 3'd0;
          state_next   = DATA;
        end else begin
          timer_next = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_next = '0;
          shift_next = shift_q >> 1;
          if (bit_cnt == 3'd7) begin
            stop_cnt_next = 1'b0;
            state_next    = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end else begin
          timer_next = timer_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          timer_next    = '0;
          stop_cnt_next = 1'b0;
          state_next    = STOP;
        end else begin
          timer_next = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_next = '0;
          if (two_stop_q && !stop_cnt) begin
            stop_cnt_next = 1'b1;
          end else if (can_load) begin
            load       = 1'b1;
            state_next = START;
          end else begin
            set_txc    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_q + 1'b1;
        end
      end
      default: begin
        timer_next = '0;
        state_next = IDLE;
      end
    endcase

    if (load) begin
      shift_next = buf_q;
    end

    // Outputs are derived from the next state so txd/busy come straight from flops
    txd_next  = 1'b1;
    busy_next = 1'b1;
    case (state_next)
      IDLE:    busy_next = 1'b0;
      START:   txd_next  = 1'b0;
      DATA:    txd_next  = shift_next[0];
      PARITY:  txd_next  = par_bit_q;
      STOP:    txd_next  = 1'b1;
      default: busy_next = 1'b0;
    endcase
  end

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      state      <= IDLE;
      buf_q      <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      udre       <= 1'b1;
      txc        <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state    <= state_next;
      shift_q  <= shift_next;
      timer_q  <= timer_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
      txd      <= txd_next;
      busy     <= busy_next;

      // Frame settings are frozen at transfer; parity is precomputed before shifting starts
      if (load) begin
        div_q      <= baudDivisor;
        par_en_q   <= parityEnable;
        par_bit_q  <= parity_of(buf_q, parityOdd);
        two_stop_q <= twoStopBits;
        udre       <= 1'b1;
      end else if (dataWrite && udre) begin
        buf_q <= dataIn;
        udre  <= 1'b0;
      end

      if (set_txc) begin
        txc <= 1'b1;
      end else if (txcClear) begin
        txc <= 1'b0;
      end
    end
  end

endmodule
